// File: rtl/code_lock_pkg.sv
`default_nettype none
// ============================================================================
// Module   : code_lock_pkg
// Brief    : Shared types and 7-segment glyphs for the code lock
//            (glyphs used when CODE_LOCK_HEX_EN is defined).
// Revision : 1.0
// ============================================================================
package code_lock_pkg;

    typedef enum logic [1:0] {
        ST_ENTRY   = 2'd0,
        ST_OPEN    = 2'd1,
        ST_CLOSED  = 2'd2,
        ST_LOCKOUT = 2'd3
    } state_t;

    typedef enum logic [2:0] {
        DISP_BLANK   = 3'd0,
        DISP_DIGIT   = 3'd1,
        DISP_ERROR   = 3'd2,
        DISP_OPEN    = 3'd3,
        DISP_CLOSED  = 3'd4,
        DISP_LOCKOUT = 3'd5
    } disp_mode_t;

    // Active-low segments, bit 6 = g ... bit 0 = a
    localparam logic [6:0] c_SEG_0   = 7'h40;
    localparam logic [6:0] c_SEG_1   = 7'h79;
    localparam logic [6:0] c_SEG_2   = 7'h24;
    localparam logic [6:0] c_SEG_3   = 7'h30;
    localparam logic [6:0] c_SEG_4   = 7'h19;
    localparam logic [6:0] c_SEG_5   = 7'h12;
    localparam logic [6:0] c_SEG_6   = 7'h02;
    localparam logic [6:0] c_SEG_7   = 7'h78;
    localparam logic [6:0] c_SEG_8   = 7'h00;
    localparam logic [6:0] c_SEG_9   = 7'h10;
    localparam logic [6:0] c_SEG_O   = 7'h40;
    localparam logic [6:0] c_SEG_C   = 7'h46;
    localparam logic [6:0] c_SEG_E   = 7'h06;
    localparam logic [6:0] c_SEG_R   = 7'h2F;
    localparam logic [6:0] c_SEG_P   = 7'h0C;
    localparam logic [6:0] c_SEG_N   = 7'h2B;
    localparam logic [6:0] c_SEG_L   = 7'h47;
    localparam logic [6:0] c_SEG_S   = 7'h12;
    localparam logic [6:0] c_SEG_D   = 7'h21;
    localparam logic [6:0] c_SEG_OFF = 7'h7F;

    function automatic logic [6:0] seg_digit(input logic [3:0] d);
        logic [6:0] s;
        case (d)
            4'd0:    s = c_SEG_0;
            4'd1:    s = c_SEG_1;
            4'd2:    s = c_SEG_2;
            4'd3:    s = c_SEG_3;
            4'd4:    s = c_SEG_4;
            4'd5:    s = c_SEG_5;
            4'd6:    s = c_SEG_6;
            4'd7:    s = c_SEG_7;
            4'd8:    s = c_SEG_8;
            4'd9:    s = c_SEG_9;
            default: s = c_SEG_OFF;
        endcase
        return s;
    endfunction

endpackage
`default_nettype wire

// File: rtl/code_lock_if.sv
`default_nettype none
// ============================================================================
// Module   : code_lock_if
// Brief    : Digit-entry / status bundle of the code lock; the hex bus
//            exists only when CODE_LOCK_HEX_EN is defined.
// Revision : 1.0
// ============================================================================
interface code_lock_if #(
    parameter int DIGITS   = 6,
    parameter int MAX_FAIL = 3
);
    localparam int c_IDX_W  = $clog2(DIGITS + 1);
    localparam int c_FAIL_W = $clog2(MAX_FAIL + 1);

    logic [3:0]          digit;
    logic                digit_valid;
    logic                retry;
    logic                is_open;
    logic                is_closed;
    logic                locked_out;
    logic                bad_digit;
    logic [c_IDX_W-1:0]  digit_idx;
    logic [c_FAIL_W-1:0] fail_cnt;
`ifdef CODE_LOCK_HEX_EN
    logic [41:0]         hex;

    modport master (output digit, digit_valid, retry,
                    input  is_open, is_closed, locked_out, bad_digit, digit_idx, fail_cnt, hex);
    modport slave  (input  digit, digit_valid, retry,
                    output is_open, is_closed, locked_out, bad_digit, digit_idx, fail_cnt, hex);
`else
    modport master (output digit, digit_valid, retry,
                    input  is_open, is_closed, locked_out, bad_digit, digit_idx, fail_cnt);
    modport slave  (input  digit, digit_valid, retry,
                    output is_open, is_closed, locked_out, bad_digit, digit_idx, fail_cnt);
`endif
endinterface
`default_nettype wire

// File: rtl/code_lock_seg7.sv
`default_nettype none
// ============================================================================
// Module   : code_lock_seg7
// Brief    : Maps display mode / digit to six active-low 7-segment glyphs
//            (HEX5..HEX0, text right-justified). Used under CODE_LOCK_HEX_EN.
// Revision : 1.0
// ============================================================================
module code_lock_seg7
    import code_lock_pkg::*;
(
    input  disp_mode_t  i_mode,
    input  logic [3:0]  i_digit,
    output logic [41:0] o_hex
);

    always_comb begin
        o_hex = {6{c_SEG_OFF}};
        case (i_mode)
            DISP_DIGIT:   o_hex = {{5{c_SEG_OFF}}, seg_digit(i_digit)};
            DISP_ERROR:   o_hex = {c_SEG_OFF, c_SEG_E, c_SEG_R, c_SEG_R, c_SEG_O, c_SEG_R};
            DISP_OPEN:    o_hex = {c_SEG_OFF, c_SEG_OFF, c_SEG_O, c_SEG_P, c_SEG_E, c_SEG_N};
            DISP_CLOSED:  o_hex = {c_SEG_C, c_SEG_L, c_SEG_O, c_SEG_S, c_SEG_E, c_SEG_D};
            DISP_LOCKOUT: o_hex = {c_SEG_OFF, c_SEG_OFF, c_SEG_L, c_SEG_O, c_SEG_C, c_SEG_D};
            default:      o_hex = {6{c_SEG_OFF}};
        endcase
    end

endmodule
`default_nettype wire

// File: rtl/code_lock_fsm.sv
`default_nettype none
// ============================================================================
// Module   : code_lock_fsm
// Brief    : Parametrised BCD combination lock with retry, failed-attempt
//            lockout and bad-digit flag; CODE_LOCK_HEX_EN adds a HEX display.
// Revision : 1.0
// ============================================================================
module code_lock_fsm
    import code_lock_pkg::*;
#(
    parameter int                  DIGITS         = 6,
    parameter logic [4*DIGITS-1:0] CODE           = 24'h722297,
    parameter int                  MAX_FAIL       = 3,
    parameter int                  LOCKOUT_CYCLES = 16
) (
    input logic        clk,
    input logic        rst,
    code_lock_if.slave bus
);

    localparam int c_IDX_W  = $clog2(DIGITS + 1);
    localparam int c_FAIL_W = $clog2(MAX_FAIL + 1);
    localparam int c_CNT_W  = (LOCKOUT_CYCLES > 1) ? $clog2(LOCKOUT_CYCLES) : 1;

    state_t              r_state;
    logic [c_IDX_W-1:0]  r_digit_idx;
    logic                r_mismatch;
    logic [c_FAIL_W-1:0] r_fail_cnt;
    logic [c_CNT_W-1:0]  r_lock_cnt;
    logic                r_bad_digit;

    logic [3:0] w_code_nibble;
    logic       w_digit_ok;
    logic       w_final;
    logic       w_any_mismatch;
    logic       w_fail_limit;

    // First entered digit is the most-significant nibble of CODE
    always_comb begin
        w_code_nibble = 4'd0;
        for (int i = 0; i < DIGITS; i++) begin
            if (r_digit_idx == c_IDX_W'(i)) begin
                w_code_nibble = CODE[4*(DIGITS-1-i) +: 4];
            end
        end
    end

    assign w_digit_ok     = (bus.digit <= 4'd9);
    assign w_final        = (r_digit_idx == c_IDX_W'(DIGITS - 1));
    assign w_any_mismatch = r_mismatch | (bus.digit != w_code_nibble);
    assign w_fail_limit   = ((int'(r_fail_cnt) + 1) >= MAX_FAIL);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= ST_ENTRY;
            r_digit_idx <= '0;
            r_mismatch  <= 1'b0;
            r_fail_cnt  <= '0;
            r_lock_cnt  <= '0;
            r_bad_digit <= 1'b0;
        end else begin
            r_bad_digit <= 1'b0;
            case (r_state)
                ST_ENTRY: begin
                    if (bus.retry) begin
                        r_digit_idx <= '0;
                        r_mismatch  <= 1'b0;
                    end else if (bus.digit_valid && !w_digit_ok) begin
                        r_bad_digit <= 1'b1;
                    end else if (bus.digit_valid) begin
                        r_digit_idx <= r_digit_idx + 1'b1;
                        r_mismatch  <= w_any_mismatch;
                        if (w_final) begin
                            if (!w_any_mismatch) begin
                                r_state    <= ST_OPEN;
                                r_fail_cnt <= '0;
                            end else if (w_fail_limit) begin
                                r_state    <= ST_LOCKOUT;
                                r_fail_cnt <= c_FAIL_W'(MAX_FAIL);
                                r_lock_cnt <= c_CNT_W'(LOCKOUT_CYCLES - 1);
                            end else begin
                                r_state    <= ST_CLOSED;
                                r_fail_cnt <= r_fail_cnt + 1'b1;
                            end
                        end
                    end
                end
                ST_OPEN, ST_CLOSED: begin
                    if (bus.retry) begin
                        r_state     <= ST_ENTRY;
                        r_digit_idx <= '0;
                        r_mismatch  <= 1'b0;
                        if (r_state == ST_OPEN) begin
                            r_fail_cnt <= '0;
                        end
                    end
                end
                ST_LOCKOUT: begin
                    if (r_lock_cnt == '0) begin
                        r_state     <= ST_ENTRY;
                        r_fail_cnt  <= '0;
                        r_digit_idx <= '0;
                        r_mismatch  <= 1'b0;
                    end else begin
                        r_lock_cnt <= r_lock_cnt - 1'b1;
                    end
                end
                default: r_state <= ST_ENTRY;
            endcase
        end
    end

    assign bus.is_open    = (r_state == ST_OPEN);
    assign bus.is_closed  = (r_state == ST_CLOSED);
    assign bus.locked_out = (r_state == ST_LOCKOUT);
    assign bus.bad_digit  = r_bad_digit;
    assign bus.digit_idx  = r_digit_idx;
    assign bus.fail_cnt   = r_fail_cnt;

`ifdef CODE_LOCK_HEX_EN
    logic       r_err_shown;
    logic [3:0] r_last_digit;
    disp_mode_t w_mode;

    // "ErrOr" persists from an invalid digit until the next accepted one
    always_ff @(posedge clk) begin
        if (rst) begin
            r_err_shown  <= 1'b0;
            r_last_digit <= 4'd0;
        end else if (r_state != ST_ENTRY || bus.retry) begin
            r_err_shown <= 1'b0;
        end else if (bus.digit_valid) begin
            if (w_digit_ok) begin
                r_err_shown  <= 1'b0;
                r_last_digit <= bus.digit;
            end else begin
                r_err_shown <= 1'b1;
            end
        end
    end

    always_comb begin
        w_mode = DISP_BLANK;
        case (r_state)
            ST_OPEN:    w_mode = DISP_OPEN;
            ST_CLOSED:  w_mode = DISP_CLOSED;
            ST_LOCKOUT: w_mode = DISP_LOCKOUT;
            default: begin
                if (r_err_shown) begin
                    w_mode = DISP_ERROR;
                end else if (r_digit_idx != '0) begin
                    w_mode = DISP_DIGIT;
                end
            end
        endcase
    end

    code_lock_seg7 u_seg7 (
        .i_mode  (w_mode),
        .i_digit (r_last_digit),
        .o_hex   (bus.hex)
    );
`endif

endmodule
`default_nettype wire

// File: tb/tb_code_lock_fsm.sv
`default_nettype none
// ============================================================================
// Module   : tb_code_lock_fsm
// Brief    : Scoreboard bench for two code_lock_fsm builds (6-digit default
//            code, 4-digit 1234); hex checked when CODE_LOCK_HEX_EN is set.
// Revision : 1.0
// ============================================================================
module tb_code_lock_fsm;

    localparam int c_MAX_FAIL = 3;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    code_lock_if #(.DIGITS(6), .MAX_FAIL(c_MAX_FAIL)) if_a ();
    code_lock_if #(.DIGITS(4), .MAX_FAIL(c_MAX_FAIL)) if_b ();

    code_lock_fsm #(.DIGITS(6), .CODE(24'h722297), .MAX_FAIL(c_MAX_FAIL), .LOCKOUT_CYCLES(8))
        u_dut_a (.clk(clk), .rst(rst), .bus(if_a.slave));
    code_lock_fsm #(.DIGITS(4), .CODE(16'h1234), .MAX_FAIL(c_MAX_FAIL), .LOCKOUT_CYCLES(16))
        u_dut_b (.clk(clk), .rst(rst), .bus(if_b.slave));

    typedef struct {
        int st;    // 0 entry, 1 open, 2 closed, 3 lockout
        int idx;
        bit mism;
        int fail;
        int left;  // lockout cycles still to spend
        bit bad;
        bit err;
        int last;
    } mdl_t;

    typedef struct {
        mdl_t a;
        mdl_t b;
    } exp_t;

    exp_t sb_q[$];
    mdl_t m_a, m_b;
    int   n_cmp  = 0;
    int   n_fail = 0;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic mdl_t mdl_zero();
        mdl_t z;
        z.st = 0; z.idx = 0; z.mism = 1'b0; z.fail = 0;
        z.left = 0; z.bad = 1'b0; z.err = 1'b0; z.last = 0;
        return z;
    endfunction

    function automatic mdl_t mdl_step(input mdl_t m, input int d, input bit v, input bit r,
                                      input bit rs, input int nd, input logic [23:0] code,
                                      input int lck);
        mdl_t       n;
        logic [3:0] want;
        n     = m;
        n.bad = 1'b0;
        if (rs) return mdl_zero();
        if (m.st == 0) begin
            if (r) begin
                n.idx = 0; n.mism = 1'b0; n.err = 1'b0;
            end else if (v && d > 9) begin
                n.bad = 1'b1; n.err = 1'b1;
            end else if (v) begin
                want   = code[4*(nd-1-m.idx) +: 4];
                n.last = d;
                n.err  = 1'b0;
                n.idx  = m.idx + 1;
                if (want != 4'(d)) n.mism = 1'b1;
                if (n.idx == nd) begin
                    if (!n.mism) begin
                        n.st = 1; n.fail = 0;
                    end else if (m.fail + 1 == c_MAX_FAIL) begin
                        n.st = 3; n.fail = c_MAX_FAIL; n.left = lck;
                    end else begin
                        n.st = 2; n.fail = m.fail + 1;
                    end
                end
            end
        end else if (m.st == 3) begin
            n.left = m.left - 1;
            if (n.left == 0) n = mdl_zero();
        end else if (r) begin
            n.st = 0; n.idx = 0; n.mism = 1'b0; n.err = 1'b0;
            if (m.st == 1) n.fail = 0;
        end
        return n;
    endfunction

`ifdef CODE_LOCK_HEX_EN
    function automatic logic [6:0] glyph(input int d);
        logic [6:0] t [10];
        t = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78, 7'h00, 7'h10};
        return t[d];
    endfunction

    function automatic logic [41:0] exp_hex(input mdl_t m);
        logic [6:0] off;
        off = 7'h7F;
        case (m.st)
            1:       return {off, off, 7'h40, 7'h0C, 7'h06, 7'h2B};
            2:       return {7'h46, 7'h47, 7'h40, 7'h12, 7'h06, 7'h21};
            3:       return {off, off, 7'h47, 7'h40, 7'h46, 7'h21};
            default: begin
                if (m.err)        return {off, 7'h06, 7'h2F, 7'h2F, 7'h40, 7'h2F};
                else if (m.idx == 0) return {6{off}};
                else              return {{5{off}}, glyph(m.last)};
            end
        endcase
    endfunction
`endif

    task automatic check_dut(input string p, input mdl_t m, input logic op, input logic cl,
                             input logic lo, input logic bd, input int idx, input int fc);
        check_eq({p, "_is_open"},    64'(op),  64'(m.st == 1));
        check_eq({p, "_is_closed"},  64'(cl),  64'(m.st == 2));
        check_eq({p, "_locked_out"}, 64'(lo),  64'(m.st == 3));
        check_eq({p, "_bad_digit"},  64'(bd),  64'(m.bad));
        check_eq({p, "_digit_idx"},  64'(idx), 64'(m.idx));
        check_eq({p, "_fail_cnt"},   64'(fc),  64'(m.fail));
    endtask

    always @(negedge clk) begin
        exp_t e;
        if (sb_q.size() > 0) begin
            e = sb_q.pop_front();
            check_dut("a", e.a, if_a.is_open, if_a.is_closed, if_a.locked_out, if_a.bad_digit,
                      int'(if_a.digit_idx), int'(if_a.fail_cnt));
            check_dut("b", e.b, if_b.is_open, if_b.is_closed, if_b.locked_out, if_b.bad_digit,
                      int'(if_b.digit_idx), int'(if_b.fail_cnt));
`ifdef CODE_LOCK_HEX_EN
            check_eq("a_hex", 64'(if_a.hex), 64'(exp_hex(e.a)));
            check_eq("b_hex", 64'(if_b.hex), 64'(exp_hex(e.b)));
`endif
        end
    end

    // sel: 0 drives lock A, 1 drives lock B, anything else leaves both idle
    task automatic cyc(input int sel, input int d, input bit v, input bit r, input bit rs);
        exp_t e;
        rst              = rs;
        if_a.digit       = (sel == 0) ? 4'(d) : 4'd0;
        if_a.digit_valid = (sel == 0) && v;
        if_a.retry       = (sel == 0) && r;
        if_b.digit       = (sel == 1) ? 4'(d) : 4'd0;
        if_b.digit_valid = (sel == 1) && v;
        if_b.retry       = (sel == 1) && r;
        m_a = mdl_step(m_a, d, (sel == 0) && v, (sel == 0) && r, rs, 6, 24'h722297, 8);
        m_b = mdl_step(m_b, d, (sel == 1) && v, (sel == 1) && r, rs, 4, 24'h001234, 16);
        e.a = m_a;
        e.b = m_b;
        sb_q.push_back(e);
        @(posedge clk);
        @(negedge clk);
        #1;
    endtask

    task automatic digits(input int sel, input int ds[8], input int n);
        for (int i = 0; i < n; i++) cyc(sel, ds[i], 1'b1, 1'b0, 1'b0);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cyc(2, 0, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic retry(input int sel);
        cyc(sel, 0, 1'b0, 1'b1, 1'b0);
    endtask

    initial begin
        m_a = mdl_zero();
        m_b = mdl_zero();
        if_a.digit = 4'd0; if_a.digit_valid = 1'b0; if_a.retry = 1'b0;
        if_b.digit = 4'd0; if_b.digit_valid = 1'b0; if_b.retry = 1'b0;

        cyc(2, 0, 1'b0, 1'b0, 1'b1);
        cyc(2, 0, 1'b0, 1'b0, 1'b1);
        idle(1);

        // correct code, then digits ignored while OPEN
        digits(0, '{7, 2, 2, 2, 9, 7, 0, 0}, 6);
        cyc(0, 3, 1'b1, 1'b0, 1'b0);
        retry(0);

        // wrong first digit, digit ignored in CLOSED, retry beats a same-cycle digit
        digits(0, '{8, 2, 2, 2, 9, 7, 0, 0}, 6);
        cyc(0, 4, 1'b1, 1'b0, 1'b0);
        cyc(0, 5, 1'b1, 1'b1, 1'b0);

        // invalid digit mid-entry, then success clears fail_cnt
        digits(0, '{7, 2, 10, 2, 2, 9, 7, 0}, 7);
        retry(0);

        // invalid digit together with retry: no pulse
        digits(0, '{7, 0, 0, 0, 0, 0, 0, 0}, 1);
        cyc(0, 15, 1'b1, 1'b1, 1'b0);

        // three failures -> lockout, correct digits ignored throughout
        digits(0, '{8, 2, 2, 2, 9, 7, 0, 0}, 6);
        retry(0);
        digits(0, '{7, 2, 2, 2, 9, 8, 0, 0}, 6);
        retry(0);
        digits(0, '{1, 1, 1, 1, 1, 1, 0, 0}, 6);
        digits(0, '{7, 2, 2, 2, 9, 7, 7, 7}, 8);
        idle(2);

        // reset in the third lockout cycle
        digits(0, '{0, 0, 0, 0, 0, 0, 0, 0}, 6);
        retry(0);
        digits(0, '{9, 9, 9, 9, 9, 9, 0, 0}, 6);
        retry(0);
        digits(0, '{7, 2, 2, 2, 9, 6, 0, 0}, 6);
        idle(2);
        cyc(2, 0, 1'b0, 1'b0, 1'b1);
        idle(2);

        // 4-digit lock
        digits(1, '{1, 2, 3, 4, 0, 0, 0, 0}, 4);
        retry(1);
        digits(1, '{1, 2, 12, 3, 5, 0, 0, 0}, 5);
        retry(1);
        digits(1, '{1, 2, 3, 4, 0, 0, 0, 0}, 4);
        idle(2);

        @(negedge clk);
        #1;
        check_eq("scoreboard_drained", 64'(sb_q.size()), 64'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
